mips_store_checker: RTL and testbench

Synthesizable responder on the single-cycle MIPS core's data-store bus (`mem_write`, `data_addr`, `write_data`). It judges the program's stores and produces sticky pass/fail/timeout verdicts. It also keeps a small overwrite-on-full log of recent stores that a host or FPGA debug port can drain. It sits beside the data memory under `top`, so self-checking programs can run in hardware without a simulator bench.

---
 rtl/checker_pkg.sv | 18 +
 rtl/mips_store_checker_if.sv | 21 ++
 rtl/store_log_fifo.sv | 56 +++++
 rtl/mips_store_checker.sv | 96 +++++++++
 tb/tb_mips_store_checker.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/checker_pkg.sv
// Shared types and constants for the MIPS store checker.
package checker_pkg;

    typedef enum logic [1:0] {
        RUN,
        PASS,
        FAIL,
        TMO
    } chk_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } store_entry_t;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/mips_store_checker_if.sv
// Data-store bus of the single-cycle MIPS core.
// The core is the master and the checker listens as a slave.
interface mips_store_checker_if;

    logic        mem_write;
    logic [31:0] data_addr;
    logic [31:0] write_data;

    modport master (
        output mem_write,
        output data_addr,
        output write_data
    );

    modport slave (
        input mem_write,
        input data_addr,
        input write_data
    );

endinterface

// File: rtl/store_log_fifo.sv
// Circular log of recent stores with show-ahead head and overwrite-on-full.
// A wrap bit above each pointer distinguishes full from empty.
module store_log_fifo
    import checker_pkg::*;
#(
    parameter int LOG_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  store_entry_t push_entry,
    input  logic         pop,
    output logic         empty,
    output store_entry_t head_entry,
    output logic         overflow
);

    localparam int PTR_W = $clog2(LOG_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    store_entry_t     entries [LOG_DEPTH];
    logic [PTR_W:0]   head_ptr;
    logic [PTR_W:0]   tail_ptr;
    logic             full;
    logic             do_pop;

    assign empty      = (head_ptr == tail_ptr);
    assign full       = (head_ptr[PTR_W] != tail_ptr[PTR_W]) &&
                        (head_ptr[PTR_W-1:0] == tail_ptr[PTR_W-1:0]);
    assign do_pop     = pop && !empty;
    assign head_entry = empty ? '0 : entries[head_ptr[PTR_W-1:0]];

    // A push when full without a pop drops the oldest entry by dragging the head along.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < LOG_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (push) begin
                entries[tail_ptr[PTR_W-1:0]] <= push_entry;
                tail_ptr <= tail_ptr + PTR_ONE;
            end
            if (do_pop || (push && full)) begin
                head_ptr <= head_ptr + PTR_ONE;
            end
            if (push && full && !do_pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_store_checker.sv
// Watches the core's data stores and latches a pass/fail/timeout verdict,
// counting accepted stores and logging them for a debug host to drain.
module mips_store_checker
    import checker_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR  = 32'd84,
    parameter logic [31:0] PASS_DATA  = 32'd7,
    parameter logic [31:0] ALLOW_ADDR = 32'd80,
    parameter int          TIMEOUT    = 1000,
    parameter int          LOG_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_store_checker_if.slave  bus,
    input  logic                 log_pop,
    output logic                 log_empty,
    output logic [31:0]          log_addr,
    output logic [31:0]          log_data,
    output logic                 log_overflow,
    output logic [15:0]          store_count,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    chk_state_t       state;
    chk_state_t       next_state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             accept;
    store_entry_t     head_entry;
    store_entry_t     new_entry;

    assign accept    = (state == RUN) && bus.mem_write;
    assign new_entry = '{addr: bus.data_addr, data: bus.write_data};

    assign pass    = (state == PASS);
    assign fail    = (state == FAIL);
    assign timeout = (state == TMO);
    assign done    = (state != RUN);

    assign log_addr = head_entry.addr;
    assign log_data = head_entry.data;

    // Verdict selection: a completing store beats an illegal one, and any verdict store beats the timeout.
    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (bus.mem_write && bus.data_addr == PASS_ADDR && bus.write_data == PASS_DATA) begin
                    next_state = PASS;
                end else if (bus.mem_write && bus.data_addr != ALLOW_ADDR) begin
                    next_state = FAIL;
                end else if (tmo_cnt == TMO_LAST) begin
                    next_state = TMO;
                end
            end
            default: next_state = state;
        endcase
    end

    // State, timeout counter and saturating store count; verdict states freeze everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            tmo_cnt     <= '0;
            store_count <= '0;
        end else begin
            state <= next_state;
            if (state == RUN && next_state == RUN) begin
                tmo_cnt <= tmo_cnt + CNT_ONE;
            end
            if (accept && store_count != COUNT_MAX) begin
                store_count <= store_count + 16'd1;
            end
        end
    end

    store_log_fifo #(
        .LOG_DEPTH (LOG_DEPTH)
    ) u_log (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_entry (new_entry),
        .pop        (log_pop),
        .empty      (log_empty),
        .head_entry (head_entry),
        .overflow   (log_overflow)
    );

endmodule

// File: tb/tb_mips_store_checker.sv
// Bench for mips_store_checker: directed scenarios plus random store traffic,
// all checked against a queue-based behavioural model of the checker.
module tb_mips_store_checker;

    localparam int TIMEOUT   = 16;
    localparam int LOG_DEPTH = 4;

    localparam int V_NONE = 0;
    localparam int V_PASS = 1;
    localparam int V_FAIL = 2;
    localparam int V_TMO  = 3;

    logic        clk;
    logic        reset;
    logic        log_pop;
    logic        log_empty;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic        log_overflow;
    logic [15:0] store_count;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;

    mips_store_checker_if bus_if ();

    mips_store_checker #(
        .PASS_ADDR  (32'd84),
        .PASS_DATA  (32'd7),
        .ALLOW_ADDR (32'd80),
        .TIMEOUT    (TIMEOUT),
        .LOG_DEPTH  (LOG_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_if),
        .log_pop      (log_pop),
        .log_empty    (log_empty),
        .log_addr     (log_addr),
        .log_data     (log_data),
        .log_overflow (log_overflow),
        .store_count  (store_count),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout)
    );

    int tests_run = 0;
    int tests_failed = 0;

    int          m_verdict = V_NONE;
    int          m_cycles = 0;
    int          m_count = 0;
    bit          m_overflow = 1'b0;
    logic [63:0] m_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic modelStep(input bit rst_n, input bit mw, input logic [31:0] a,
                             input logic [31:0] d, input bit pop);
        if (!rst_n) begin
            m_verdict  = V_NONE;
            m_cycles   = 0;
            m_count    = 0;
            m_overflow = 1'b0;
            m_q.delete();
        end else begin
            if (pop && m_q.size() > 0) void'(m_q.pop_front());
            if (m_verdict == V_NONE) begin
                m_cycles++;
                if (mw) begin
                    if (m_count < 65535) m_count++;
                    if (m_q.size() == LOG_DEPTH) begin
                        void'(m_q.pop_front());
                        m_overflow = 1'b1;
                    end
                    m_q.push_back({a, d});
                    if (a == 32'd84 && d == 32'd7) m_verdict = V_PASS;
                    else if (a != 32'd80) m_verdict = V_FAIL;
                end
                if (m_verdict == V_NONE && m_cycles >= TIMEOUT) m_verdict = V_TMO;
            end
        end
    endtask

    task automatic compareAll();
        logic [63:0] head;
        checkOutput("done", 32'(done), 32'(m_verdict != V_NONE));
        checkOutput("pass", 32'(pass), 32'(m_verdict == V_PASS));
        checkOutput("fail", 32'(fail), 32'(m_verdict == V_FAIL));
        checkOutput("timeout", 32'(timeout), 32'(m_verdict == V_TMO));
        checkOutput("store_count", 32'(store_count), 32'(m_count));
        checkOutput("log_empty", 32'(log_empty), 32'(m_q.size() == 0));
        checkOutput("log_overflow", 32'(log_overflow), 32'(m_overflow));
        if (m_q.size() > 0) begin
            head = m_q[0];
            checkOutput("log_addr", log_addr, head[63:32]);
            checkOutput("log_data", log_data, head[31:0]);
        end
    endtask

    task automatic applyStimulus(input bit rst_n, input bit mw, input logic [31:0] a,
                                 input logic [31:0] d, input bit pop);
        reset               = rst_n;
        bus_if.mem_write    = mw;
        bus_if.data_addr    = a;
        bus_if.write_data   = d;
        log_pop             = pop;
        @(posedge clk);
        modelStep(rst_n, mw, a, d, pop);
        #1;
        compareAll();
    endtask

    task automatic checkResetValues();
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_count", 32'(store_count), 32'd0);
        checkOutput("rst_empty", 32'(log_empty), 32'd1);
        checkOutput("rst_overflow", 32'(log_overflow), 32'd0);
        checkOutput("rst_log_addr", log_addr, 32'd0);
        checkOutput("rst_log_data", log_data, 32'd0);
    endtask

    initial begin
        bit          mw;
        bit          pop;
        bit          rst_n;
        logic [31:0] a;
        logic [31:0] d;
        int          r;

        reset             = 1'b0;
        bus_if.mem_write  = 1'b0;
        bus_if.data_addr  = '0;
        bus_if.write_data = '0;
        log_pop           = 1'b0;

        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkResetValues();

        // Legal store then completion, then drain the log.
        applyStimulus(1, 1, 32'd80, 32'd3, 0);
        applyStimulus(1, 1, 32'd84, 32'd7, 0);
        checkOutput("pass_after_two", 32'(pass), 32'd1);
        checkOutput("count_two", 32'(store_count), 32'd2);
        repeat (3) applyStimulus(1, 0, 0, 0, 1);
        checkOutput("drained_empty", 32'(log_empty), 32'd1);

        // Wrong data at the completion address fails; later stores are ignored.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'd84, 32'd6, 0);
        checkOutput("fail_wrong_data", 32'(fail), 32'd1);
        applyStimulus(1, 1, 32'd84, 32'd7, 0);
        checkOutput("ignored_count", 32'(store_count), 32'd1);
        checkOutput("ignored_pass", 32'(pass), 32'd0);

        // Illegal address fails and shows up at the log head.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'd100, 32'd7, 0);
        checkOutput("fail_bad_addr", 32'(fail), 32'd1);
        checkOutput("bad_addr_head", log_addr, 32'd100);

        // Idle run: timeout exactly TIMEOUT edges after reset release.
        applyStimulus(0, 0, 0, 0, 0);
        repeat (TIMEOUT - 1) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("no_tmo_early", 32'(timeout), 32'd0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("tmo_on_time", 32'(timeout), 32'd1);

        // Completion on the timeout edge wins.
        applyStimulus(0, 0, 0, 0, 0);
        repeat (TIMEOUT - 1) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'd84, 32'd7, 0);
        checkOutput("race_pass", 32'(pass), 32'd1);
        checkOutput("race_tmo", 32'(timeout), 32'd0);

        // Overwrite on full without pops.
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) applyStimulus(1, 1, 32'd80, 32'(i), 0);
        checkOutput("overflow_set", 32'(log_overflow), 32'd1);
        for (int i = 3; i <= 6; i++) begin
            checkOutput("overflow_order", log_data, 32'(i));
            applyStimulus(1, 0, 0, 0, 1);
        end

        // Push with pop when full is not an overflow.
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(1, 1, 32'd80, 32'(i), 0);
        for (int i = 5; i <= 6; i++) applyStimulus(1, 1, 32'd80, 32'(i), 1);
        checkOutput("no_overflow", 32'(log_overflow), 32'd0);
        for (int i = 3; i <= 6; i++) begin
            checkOutput("pushpop_order", log_data, 32'(i));
            applyStimulus(1, 0, 0, 0, 1);
        end

        // Reset in the middle of a PASS, then pass again.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'd84, 32'd7, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkResetValues();
        applyStimulus(1, 1, 32'd84, 32'd7, 0);
        checkOutput("repass", 32'(pass), 32'd1);

        // Random traffic against the model.
        applyStimulus(0, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if (m_verdict != V_NONE && $urandom_range(0, 5) == 0) rst_n = 1'b0;
            mw  = ($urandom_range(0, 2) == 0);
            pop = ($urandom_range(0, 2) == 0);
            r   = int'($urandom_range(0, 11));
            if (r < 8) begin
                a = 32'd80;
                d = $urandom;
            end else if (r < 11) begin
                a = 32'd84;
                d = ($urandom_range(0, 1) == 0) ? 32'd7 : 32'($urandom_range(0, 15));
            end else begin
                a = $urandom;
                d = $urandom;
            end
            applyStimulus(rst_n, mw, a, d, pop);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
